divider_seq: RTL and testbench



---
 rtl/divider_seq_if.sv | 22 ++
 rtl/divider_seq.sv | 120 ++++++++++++
 tb/tb_divider_seq.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/divider_seq_if.sv
// rtl/divider_seq_if.sv - start/done handshake and operand/result bundle for divider_seq
interface divider_seq_if;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;
  logic        ovf;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, ovf
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, ovf
  );
endinterface

// File: rtl/divider_seq.sv
// rtl/divider_seq.sv - 16/8 signed radix-2 restoring divider, one quotient bit per cycle
module divider_seq (
  input logic          clk,
  input logic          rst_n,
  divider_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  count;
  logic [8:0]  r;
  logic [15:0] q;
  logic [7:0]  dvs;
  logic        sign_q;
  logic        sign_r;

  logic        load;
  logic        step;
  logic        fix;
  logic        dz_out;
  logic        busy;

  logic [15:0] dvd_mag;
  logic [7:0]  dvs_mag;
  logic [9:0]  r_wide;
  logic [8:0]  r_sh;
  logic [8:0]  r_diff;
  logic        ge;

  assign dvd_mag = bus.dividend[15] ? (~bus.dividend + 16'd1) : bus.dividend;
  assign dvs_mag = bus.divisor[7] ? (~bus.divisor + 8'd1) : bus.divisor;

  // r never exceeds 127 between steps, so r[8] is zero and the shift drops nothing.
  assign r_wide = {r, q[15]};
  assign r_sh   = {r[7:0], q[15]};
  assign ge     = (r_wide >= {2'b00, dvs});
  assign r_diff = r_sh - {1'b0, dvs};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = (bus.divisor == 8'd0) ? DONE : CALC;
      CALC: if (count == 4'd15) state_nxt = FIX;
      FIX:  state_nxt = IDLE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load   = 1'b0;
    step   = 1'b0;
    fix    = 1'b0;
    dz_out = 1'b0;
    busy   = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        load = bus.start;
      end
      CALC: step = 1'b1;
      FIX:  fix = 1'b1;
      DONE: dz_out = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  assign bus.busy = busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count           <= 4'd0;
      r               <= 9'd0;
      q               <= 16'd0;
      dvs             <= 8'd0;
      sign_q          <= 1'b0;
      sign_r          <= 1'b0;
      bus.done        <= 1'b0;
      bus.quotient    <= 16'd0;
      bus.remainder   <= 8'd0;
      bus.div_by_zero <= 1'b0;
      bus.ovf         <= 1'b0;
    end else begin
      bus.done <= fix | dz_out;
      if (load) begin
        count  <= 4'd0;
        // On the divide-by-zero path r carries the raw low dividend byte to the output.
        r      <= (bus.divisor == 8'd0) ? {1'b0, bus.dividend[7:0]} : 9'd0;
        q      <= dvd_mag;
        dvs    <= dvs_mag;
        sign_q <= bus.dividend[15] ^ bus.divisor[7];
        sign_r <= bus.dividend[15];
      end else if (step) begin
        count <= count + 4'd1;
        r     <= ge ? r_diff : r_sh;
        q     <= {q[14:0], ge};
      end
      if (fix) begin
        bus.quotient    <= sign_q ? (~q + 16'd1) : q;
        bus.remainder   <= sign_r ? (~r[7:0] + 8'd1) : r[7:0];
        bus.ovf         <= (q == 16'h8000) && !sign_q;
        bus.div_by_zero <= 1'b0;
      end else if (dz_out) begin
        bus.quotient    <= 16'hFFFF;
        bus.remainder   <= r[7:0];
        bus.ovf         <= 1'b0;
        bus.div_by_zero <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_divider_seq.sv
// tb/tb_divider_seq.sv - table, random and handshake/reset sequences for divider_seq
module tb_divider_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  divider_seq_if bus ();
  divider_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int total = 0;
  int bad = 0;

  typedef struct {
    logic signed [15:0] a;
    logic signed [7:0]  b;
    logic [15:0]        q;
    logic [7:0]         r;
    logic               o;
    logic               z;
    int                 lat;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer division truncates toward zero, % takes the dividend's sign.
  function automatic void model(input int a, input int b, output logic [15:0] q,
                                output logic [7:0] r, output logic o, output logic z);
    int qi;
    int ri;
    if (b == 0) begin
      q = 16'hFFFF;
      r = a[7:0];
      o = 1'b0;
      z = 1'b1;
    end else begin
      qi = a / b;
      ri = a % b;
      q  = qi[15:0];
      r  = ri[7:0];
      o  = (qi > 32767);
      z  = 1'b0;
    end
  endfunction

  task automatic launch(input logic signed [15:0] a, input logic signed [7:0] b);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input logic [15:0] eq, input logic [7:0] er,
                              input logic eo, input logic ez);
    chk({tag, "_quotient"}, bus.quotient, eq);
    chk({tag, "_remainder"}, bus.remainder, er);
    chk({tag, "_ovf"}, bus.ovf, eo);
    chk({tag, "_div_by_zero"}, bus.div_by_zero, ez);
  endtask

  task automatic run_check(input string tag, input logic signed [15:0] a, input logic signed [7:0] b,
                           input logic [15:0] eq, input logic [7:0] er, input logic eo,
                           input logic ez, input int elat);
    int lat;
    launch(a, b);
    chk({tag, "_busy_start"}, bus.busy, 1);
    wait_done(lat);
    chk({tag, "_latency"}, lat, elat);
    check_result(tag, eq, er, eo, ez);
    chk({tag, "_busy_done"}, bus.busy, 0);
    @(negedge clk);
    chk({tag, "_done_width"}, bus.done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int seen;
    logic signed [15:0] ra;
    logic signed [7:0]  rb;
    logic [15:0] mq;
    logic [7:0]  mr;
    logic        mo;
    logic        mz;

    tbl[0] = '{16'sd100,    8'sd7,    16'h000E, 8'h02, 1'b0, 1'b0, 17};
    tbl[1] = '{-16'sd100,   8'sd7,    16'hFFF2, 8'hFE, 1'b0, 1'b0, 17};
    tbl[2] = '{16'sd100,    -8'sd7,   16'hFFF2, 8'h02, 1'b0, 1'b0, 17};
    tbl[3] = '{-16'sd100,   -8'sd7,   16'h000E, 8'hFE, 1'b0, 1'b0, 17};
    tbl[4] = '{16'sd32767,  8'sh80,   16'hFF01, 8'h7F, 1'b0, 1'b0, 17};
    tbl[5] = '{16'sh8000,   -8'sd1,   16'h8000, 8'h00, 1'b1, 1'b0, 17};
    tbl[6] = '{16'sh8000,   8'sd1,    16'h8000, 8'h00, 1'b0, 1'b0, 17};
    tbl[7] = '{16'sd1234,   8'sd0,    16'hFFFF, 8'hD2, 1'b0, 1'b1, 1};
    tbl[8] = '{16'sd10,     8'sd3,    16'h0003, 8'h01, 1'b0, 1'b0, 17};

    bus.start    = 1'b0;
    bus.dividend = 16'h0;
    bus.divisor  = 8'h0;
    repeat (2) @(negedge clk);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    check_result("reset", 16'h0, 8'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", bus.busy, 0);

    for (int i = 0; i < 9; i++)
      run_check($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r,
                tbl[i].o, tbl[i].z, tbl[i].lat);

    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      rb = 8'($urandom);
      if (i % 8 == 3) rb = 8'sd0;
      if (i % 10 == 5) ra = 16'sh8000;
      if (i % 10 == 6) rb = 8'sh80;
      model(int'(ra), int'(rb), mq, mr, mo, mz);
      run_check($sformatf("rand%0d", i), ra, rb, mq, mr, mo, mz, (rb == 8'sd0) ? 1 : 17);
    end

    // start during busy is ignored and operand changes have no effect
    launch(16'sd100, 8'sd7);
    repeat (4) @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 16'sd200;
    bus.divisor  = 8'sd3;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.dividend = -16'sd5;
    bus.divisor  = 8'sd2;
    wait_done(lat);
    chk("ignore_latency", lat + 5, 17);
    check_result("ignore", 16'h000E, 8'h02, 1'b0, 1'b0);
    @(negedge clk);
    chk("ignore_no_second_done", bus.done, 0);
    chk("ignore_no_second_busy", bus.busy, 0);

    // start in the done cycle is accepted
    launch(16'sd100, 8'sd7);
    wait_done(lat);
    chk("b2b_first_latency", lat, 17);
    launch(-16'sd100, -8'sd7);
    chk("b2b_busy", bus.busy, 1);
    wait_done(lat);
    chk("b2b_second_latency", lat, 17);
    check_result("b2b", 16'h000E, 8'hFE, 1'b0, 1'b0);
    @(negedge clk);

    // reset in the middle of CALC, after an overflow result is on the outputs
    run_check("pre_reset", 16'sh8000, -8'sd1, 16'h8000, 8'h00, 1'b1, 1'b0, 17);
    launch(16'sd100, 8'sd7);
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    check_result("abort", 16'h0, 8'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    chk("abort_no_done", seen, 0);
    run_check("after_reset", 16'sd50, 8'sd5, 16'h000A, 8'h00, 1'b0, 1'b0, 17);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
